// File: rtl/lpddr2_port_arbiter.sv
// Two-requester arbiter for one LPDDR2 Avalon-MM port: video (V, read-only) and capture (W, read/write).
// Define ARB_PERF_CNT_EN to add wait-cycle and peak-occupancy performance counters.
module lpddr2_port_arbiter #(
    parameter int unsigned ADDR_W          = 27,
    parameter int unsigned DATA_W          = 32,
    parameter int unsigned MAX_OUTSTANDING = 8,
    parameter int unsigned STARVE_LIMIT    = 16
) (
    input  logic              iCLK,
    input  logic              iRST_n,
    input  logic              local_init_done,
    input  logic              v_read,
    input  logic [ADDR_W-1:0] v_addr,
    output logic              v_ready,
    output logic              v_rdata_valid,
    output logic [DATA_W-1:0] v_rdata,
    input  logic              w_read,
    input  logic              w_write,
    input  logic [ADDR_W-1:0] w_addr,
    input  logic [DATA_W-1:0] w_wdata,
    output logic              w_ready,
    output logic              w_rdata_valid,
    output logic [DATA_W-1:0] w_rdata,
    input  logic              avl_ready,
    output logic              avl_read,
    output logic              avl_write,
    output logic              avl_burstbegin,
    output logic [ADDR_W-1:0] avl_addr,
    output logic [DATA_W-1:0] avl_wdata,
    output logic [2:0]        avl_size,
    input  logic              avl_rdata_valid,
    input  logic [DATA_W-1:0] avl_rdata,
`ifdef ARB_PERF_CNT_EN
    output logic [15:0]       v_wait_cnt,
    output logic [15:0]       w_wait_cnt,
    output logic [5:0]        max_outstanding,
`endif
    output logic              rsp_err
);

    localparam int unsigned PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, GNT_V, GNT_W} state_t;

    state_t                     state;
    state_t                     state_next;
    logic                       first_cycle;
    logic [7:0]                 starve_cnt;
    logic                       starve_hit;
    logic                       w_req;
    logic                       w_ok;
    logic                       accept;

    logic [MAX_OUTSTANDING-1:0] tag_mem;
    logic [PTR_W-1:0]           wr_ptr;
    logic [PTR_W-1:0]           rd_ptr;
    logic [CNT_W-1:0]           tag_cnt;
    logic [CNT_W-1:0]           tag_cnt_next;
    logic                       tag_full;
    logic                       tag_empty;
    logic                       tag_push;
    logic                       tag_pop;
    logic                       head_tag;

    assign w_req      = w_read | w_write;
    assign tag_full   = (tag_cnt == CNT_W'(MAX_OUTSTANDING));
    assign tag_empty  = (tag_cnt == '0);
    // W is only eligible when it could complete without overflowing the tag FIFO
    assign w_ok       = w_write | (w_read & ~tag_full);
    assign starve_hit = (starve_cnt == 8'(STARVE_LIMIT));
    assign accept     = (state != IDLE) & avl_ready;
    assign tag_pop    = avl_rdata_valid & ~tag_empty;
    assign tag_push   = accept & avl_read & (~tag_full | tag_pop);
    assign head_tag   = tag_mem[rd_ptr];

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            state       <= IDLE;
            first_cycle <= 1'b0;
        end else begin
            state       <= state_next;
            first_cycle <= (state == IDLE);
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (local_init_done) begin
                    if (starve_hit && w_ok)
                        state_next = GNT_W;
                    else if (v_read && !tag_full)
                        state_next = GNT_V;
                    else if (w_ok)
                        state_next = GNT_W;
                end
            end
            GNT_V, GNT_W: begin
                if (avl_ready)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        avl_read       = 1'b0;
        avl_write      = 1'b0;
        avl_burstbegin = 1'b0;
        avl_addr       = '0;
        avl_wdata      = '0;
        v_ready        = 1'b0;
        w_ready        = 1'b0;
        case (state)
            GNT_V: begin
                avl_read       = v_read;
                avl_addr       = v_addr;
                avl_burstbegin = first_cycle;
                v_ready        = avl_ready;
            end
            GNT_W: begin
                avl_read       = w_read;
                avl_write      = w_write;
                avl_addr       = w_addr;
                avl_wdata      = w_wdata;
                avl_burstbegin = first_cycle;
                w_ready        = avl_ready;
            end
            default: ;
        endcase
    end

    assign avl_size = 3'b001;

    always_ff @(posedge iCLK) begin
        if (!iRST_n)
            starve_cnt <= '0;
        else if (((state == GNT_W) && avl_ready) || !w_req)
            starve_cnt <= '0;
        else if ((state == GNT_V) && avl_ready && !starve_hit)
            starve_cnt <= starve_cnt + 8'd1;
    end

    always_comb begin
        tag_cnt_next = tag_cnt;
        case ({tag_push, tag_pop})
            2'b10:   tag_cnt_next = tag_cnt + CNT_W'(1);
            2'b01:   tag_cnt_next = tag_cnt - CNT_W'(1);
            default: tag_cnt_next = tag_cnt;
        endcase
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            tag_mem <= '0;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            tag_cnt <= '0;
        end else begin
            if (tag_push) begin
                tag_mem[wr_ptr] <= (state == GNT_W);
                wr_ptr          <= wr_ptr + PTR_W'(1);
            end
            if (tag_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            tag_cnt <= tag_cnt_next;
        end
    end

    always_ff @(posedge iCLK) begin
        if (!iRST_n)
            rsp_err <= 1'b0;
        else if (avl_rdata_valid && tag_empty)
            rsp_err <= 1'b1;
    end

    assign v_rdata       = avl_rdata;
    assign w_rdata       = avl_rdata;
    assign v_rdata_valid = tag_pop & ~head_tag;
    assign w_rdata_valid = tag_pop & head_tag;

`ifdef ARB_PERF_CNT_EN
    always_ff @(posedge iCLK) begin
        if (!iRST_n) begin
            v_wait_cnt      <= '0;
            w_wait_cnt      <= '0;
            max_outstanding <= '0;
        end else begin
            if (v_read && !v_ready && (v_wait_cnt != '1))
                v_wait_cnt <= v_wait_cnt + 16'd1;
            if (w_req && !w_ready && (w_wait_cnt != '1))
                w_wait_cnt <= w_wait_cnt + 16'd1;
            if (6'(tag_cnt_next) > max_outstanding)
                max_outstanding <= 6'(tag_cnt_next);
        end
    end
`endif

endmodule

// File: tb/tb_lpddr2_port_arbiter.sv
// Self-checking bench for lpddr2_port_arbiter: queue-driven requesters, an in-order memory
// responder and per-requester expected-data scoreboards.
module tb_lpddr2_port_arbiter;

    logic        iCLK = 1'b0;
    logic        iRST_n;
    logic        local_init_done;
    logic        v_read;
    logic [26:0] v_addr;
    logic        v_ready, v_rdata_valid;
    logic [31:0] v_rdata;
    logic        w_read, w_write;
    logic [26:0] w_addr;
    logic [31:0] w_wdata;
    logic        w_ready, w_rdata_valid;
    logic [31:0] w_rdata;
    logic        avl_ready, avl_read, avl_write, avl_burstbegin;
    logic [26:0] avl_addr;
    logic [31:0] avl_wdata;
    logic [2:0]  avl_size;
    logic        avl_rdata_valid;
    logic [31:0] avl_rdata;
    logic        rsp_err;
`ifdef ARB_PERF_CNT_EN
    logic [15:0] v_wait_cnt, w_wait_cnt;
    logic [5:0]  max_outstanding;
`endif

    lpddr2_port_arbiter #(
        .ADDR_W(27), .DATA_W(32), .MAX_OUTSTANDING(8), .STARVE_LIMIT(16)
    ) dut (
        .iCLK(iCLK), .iRST_n(iRST_n), .local_init_done(local_init_done),
        .v_read(v_read), .v_addr(v_addr), .v_ready(v_ready),
        .v_rdata_valid(v_rdata_valid), .v_rdata(v_rdata),
        .w_read(w_read), .w_write(w_write), .w_addr(w_addr), .w_wdata(w_wdata),
        .w_ready(w_ready), .w_rdata_valid(w_rdata_valid), .w_rdata(w_rdata),
        .avl_ready(avl_ready), .avl_read(avl_read), .avl_write(avl_write),
        .avl_burstbegin(avl_burstbegin), .avl_addr(avl_addr), .avl_wdata(avl_wdata),
        .avl_size(avl_size), .avl_rdata_valid(avl_rdata_valid), .avl_rdata(avl_rdata),
`ifdef ARB_PERF_CNT_EN
        .v_wait_cnt(v_wait_cnt), .w_wait_cnt(w_wait_cnt), .max_outstanding(max_outstanding),
`endif
        .rsp_err(rsp_err)
    );

    always #5 iCLK = ~iCLK;

    typedef struct { bit wr; logic [26:0] addr; logic [31:0] data; } wop_t;
    typedef struct { int due; logic [31:0] data; } rsp_t;

    logic [26:0] v_q[$];
    wop_t        w_q[$];
    rsp_t        mem_q[$];
    logic [31:0] mem_data [bit [26:0]];
    logic [31:0] v_exp[$], v_got[$], w_exp[$], w_got[$];
    wop_t        wr_exp[$], wr_got[$];
    string       rsp_order;

    int n_cmp, n_err;
    int cyc, last_due, lat_lo, lat_hi, rsp_budget;
    bit mem_ready_rand;
    logic mem_ready;
    int v_acc_cnt, w_acc_cnt, vrun, vrun_max, w_acc_run;
    int last_v_acc_cyc, w_acc_cyc, last_v_rsp_cyc;

    logic        s_avl_read, s_avl_write, s_bb, s_v_ready, s_w_ready, s_v_rv, s_w_rv, s_rsp_err;
    logic [26:0] s_avl_addr;
    logic [31:0] s_avl_wdata;
    logic [2:0]  s_avl_size;

    function automatic logic [31:0] mem_fn(input logic [26:0] a);
        if (mem_data.exists(a)) return mem_data[a];
        return {5'b10101, a} ^ 32'h3C00_0F0F;
    endfunction

    // One clock: drive requests from the work queues, sample mid-cycle, then advance the responder.
    task automatic tick();
        bit va, wa;
        int d;
        v_read = (v_q.size() != 0);
        v_addr = v_read ? v_q[0] : '0;
        if (w_q.size() != 0) begin
            w_read = !w_q[0].wr; w_write = w_q[0].wr; w_addr = w_q[0].addr; w_wdata = w_q[0].data;
        end else begin
            w_read = 1'b0; w_write = 1'b0; w_addr = '0; w_wdata = '0;
        end
        avl_ready = mem_ready_rand ? ($urandom_range(0, 3) != 0) : mem_ready;
        @(negedge iCLK);
        s_avl_read = avl_read; s_avl_write = avl_write; s_bb = avl_burstbegin;
        s_v_ready = v_ready; s_w_ready = w_ready; s_v_rv = v_rdata_valid; s_w_rv = w_rdata_valid;
        s_rsp_err = rsp_err; s_avl_addr = avl_addr; s_avl_wdata = avl_wdata; s_avl_size = avl_size;
        va = v_read && v_ready;
        wa = (w_read || w_write) && w_ready;
        if (avl_read && avl_ready) begin
            d = cyc + 1 + $urandom_range(lat_lo, lat_hi);
            if (d <= last_due) d = last_due + 1;
            last_due = d;
            mem_q.push_back('{due: d, data: mem_fn(avl_addr)});
        end
        if (avl_write && avl_ready) wr_got.push_back('{wr: 1'b1, addr: avl_addr, data: avl_wdata});
        if (va) begin
            v_exp.push_back(mem_fn(v_addr));
            v_acc_cnt++;
            last_v_acc_cyc = cyc + 1;
            if (w_read || w_write) vrun++;
            if (vrun > vrun_max) vrun_max = vrun;
        end
        if (wa) begin
            if (w_read) w_exp.push_back(mem_fn(w_addr));
            else wr_exp.push_back(w_q[0]);
            w_acc_cnt++;
            w_acc_cyc = cyc + 1;
            w_acc_run = vrun;
            vrun = 0;
        end else if (!(w_read || w_write)) begin
            vrun = 0;
        end
        if (v_rdata_valid) begin v_got.push_back(v_rdata); rsp_order = {rsp_order, "V"}; last_v_rsp_cyc = cyc; end
        if (w_rdata_valid) begin w_got.push_back(w_rdata); rsp_order = {rsp_order, "W"}; end
        @(posedge iCLK);
        #1;
        cyc++;
        if (va) void'(v_q.pop_front());
        if (wa) void'(w_q.pop_front());
        avl_rdata_valid = 1'b0;
        avl_rdata = '0;
        if (mem_q.size() != 0 && mem_q[0].due <= cyc && rsp_budget > 0) begin
            avl_rdata_valid = 1'b1;
            avl_rdata = mem_q[0].data;
            void'(mem_q.pop_front());
            rsp_budget--;
        end
    endtask

    task automatic clear_logs();
        v_exp.delete(); v_got.delete(); w_exp.delete(); w_got.delete();
        wr_exp.delete(); wr_got.delete(); rsp_order = "";
    endtask

    task automatic test_reset();
        int nz;
        iRST_n = 1'b0; local_init_done = 1'b0;
        v_read = 0; v_addr = '0; w_read = 0; w_write = 0; w_addr = '0; w_wdata = '0;
        avl_ready = 0; avl_rdata_valid = 0; avl_rdata = '0;
        v_q.delete(); w_q.delete(); mem_q.delete(); clear_logs();
        mem_ready = 1'b1; mem_ready_rand = 0; rsp_budget = 1000000; lat_lo = 5; lat_hi = 5;
        cyc = 0; last_due = 0; vrun = 0; vrun_max = 0; v_acc_cnt = 0; w_acc_cnt = 0;
        repeat (3) @(posedge iCLK);
        #1;
        iRST_n = 1'b1;
        v_q.push_back(27'h0000ABC);
        tick();
        n_cmp++;
        if ({s_avl_read, s_avl_write, s_bb, s_v_ready, s_w_ready, s_v_rv, s_w_rv, s_rsp_err} !== 8'h00) begin
            n_err++; $display("FAIL reset_strobes: got %b want 00000000",
                {s_avl_read, s_avl_write, s_bb, s_v_ready, s_w_ready, s_v_rv, s_w_rv, s_rsp_err});
        end
        n_cmp++;
        if (s_avl_addr !== 27'h0 || s_avl_wdata !== 32'h0) begin
            n_err++; $display("FAIL reset_addr_data: got %h/%h want 0/0", s_avl_addr, s_avl_wdata);
        end
        n_cmp++;
        if (s_avl_size !== 3'b001) begin n_err++; $display("FAIL avl_size: got %b want 001", s_avl_size); end
        nz = 0;
        repeat (19) begin
            tick();
            if (s_avl_read || s_bb || s_v_ready || s_w_ready) nz++;
        end
        n_cmp++;
        if (nz != 0) begin n_err++; $display("FAIL no_init_grant: got %0d active cycles want 0", nz); end
        local_init_done = 1'b1;
        tick();
        n_cmp++;
        if (s_avl_read !== 1'b0) begin n_err++; $display("FAIL init_grant_early: got %b want 0", s_avl_read); end
        tick();
        n_cmp++;
        if ({s_avl_read, s_bb, s_avl_addr} !== {1'b1, 1'b1, 27'h0000ABC}) begin
            n_err++; $display("FAIL init_grant: got rd=%b bb=%b addr=%h want 1 1 0000abc", s_avl_read, s_bb, s_avl_addr);
        end
        for (int k = 0; k < 20 && v_got.size() < 1; k++) tick();
        n_cmp++;
        if (v_got.size() != 1 || v_exp.size() != 1 || v_got[0] !== v_exp[0]) begin
            n_err++; $display("FAIL init_read_data: got %0d responses want 1 matching", v_got.size());
        end
    endtask

    task automatic test_single_read();
        int a0;
        clear_logs();
        mem_data[27'h0001000] = 32'hDEADBEEF;
        lat_lo = 5; lat_hi = 5;
        a0 = v_acc_cnt;
        v_q.push_back(27'h0001000);
        for (int k = 0; k < 30; k++) tick();
        n_cmp++;
        if (v_acc_cnt - a0 != 1) begin n_err++; $display("FAIL single_accept: got %0d want 1", v_acc_cnt - a0); end
        n_cmp++;
        if (v_got.size() != 1) begin n_err++; $display("FAIL single_pulses: got %0d want 1", v_got.size()); end
        else begin
            n_cmp++;
            if (v_got[0] !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data: got %h want deadbeef", v_got[0]); end
            n_cmp++;
            if (last_v_rsp_cyc - last_v_acc_cyc != 5) begin
                n_err++; $display("FAIL single_latency: got %0d want 5", last_v_rsp_cyc - last_v_acc_cyc);
            end
        end
        n_cmp++;
        if (w_got.size() != 0) begin n_err++; $display("FAIL single_w_valid: got %0d want 0", w_got.size()); end
    endtask

    task automatic test_starvation();
        int w0, k;
        wop_t op;
        clear_logs();
        lat_lo = 3; lat_hi = 3;
        for (int i = 0; i < 40; i++) v_q.push_back(27'h100000 + 27'(i));
        repeat (5) tick();
        w0 = w_acc_cnt;
        op = '{wr: 1'b1, addr: 27'h0000010, data: 32'h12345678};
        w_q.push_back(op);
        k = 0;
        while (w_acc_cnt == w0 && k < 200) begin tick(); k++; end
        n_cmp++;
        if (w_acc_cnt == w0) begin n_err++; $display("FAIL starve_timeout: got no W accept want 1"); end
        else begin
            n_cmp++;
            if (w_acc_run != 16) begin n_err++; $display("FAIL starve_count: got %0d V accepts want 16", w_acc_run); end
            n_cmp++;
            if (w_acc_cyc - last_v_acc_cyc != 2) begin
                n_err++; $display("FAIL starve_spacing: got %0d want 2", w_acc_cyc - last_v_acc_cyc);
            end
            n_cmp++;
            if ({s_avl_write, s_avl_addr, s_avl_wdata} !== {1'b1, 27'h0000010, 32'h12345678}) begin
                n_err++; $display("FAIL starve_cmd: got wr=%b addr=%h data=%h want 1 0000010 12345678",
                    s_avl_write, s_avl_addr, s_avl_wdata);
            end
        end
        k = 0;
        while ((v_q.size() != 0 || mem_q.size() != 0) && k < 300) begin tick(); k++; end
        repeat (3) tick();
        n_cmp++;
        if (v_got.size() != 40 || v_exp.size() != 40) begin
            n_err++; $display("FAIL starve_v_count: got %0d/%0d want 40", v_got.size(), v_exp.size());
        end
        for (int i = 0; i < v_got.size() && i < v_exp.size(); i++) begin
            n_cmp++;
            if (v_got[i] !== v_exp[i]) begin n_err++; $display("FAIL starve_v_data[%0d]: got %h want %h", i, v_got[i], v_exp[i]); end
        end
    endtask

    task automatic test_interleave();
        int c, k;
        wop_t op;
        clear_logs();
        lat_lo = 5; lat_hi = 5;
        for (int i = 0; i < 4; i++) begin
            c = v_acc_cnt + w_acc_cnt;
            if (i % 2 == 0) v_q.push_back(27'h0200000 + 27'(i));
            else begin op = '{wr: 1'b0, addr: 27'h0300000 + 27'(i), data: '0}; w_q.push_back(op); end
            k = 0;
            while (v_acc_cnt + w_acc_cnt == c && k < 20) begin tick(); k++; end
        end
        for (int i = 0; i < 15; i++) tick();
        n_cmp++;
        if (rsp_order != "VWVW") begin n_err++; $display("FAIL interleave_order: got %s want VWVW", rsp_order); end
        n_cmp++;
        if (v_got.size() != 2 || w_got.size() != 2) begin
            n_err++; $display("FAIL interleave_count: got %0d/%0d want 2/2", v_got.size(), w_got.size());
        end else begin
            n_cmp++;
            if (v_got[0] !== mem_fn(27'h0200000) || v_got[1] !== mem_fn(27'h0200002)) begin
                n_err++; $display("FAIL interleave_v_data: got %h %h want %h %h", v_got[0], v_got[1],
                    mem_fn(27'h0200000), mem_fn(27'h0200002));
            end
            n_cmp++;
            if (w_got[0] !== mem_fn(27'h0300001) || w_got[1] !== mem_fn(27'h0300003)) begin
                n_err++; $display("FAIL interleave_w_data: got %h %h want %h %h", w_got[0], w_got[1],
                    mem_fn(27'h0300001), mem_fn(27'h0300003));
            end
        end
    endtask

    task automatic test_full_fifo();
        int v0, w0, k;
        wop_t op;
        clear_logs();
        lat_lo = 1; lat_hi = 1;
        rsp_budget = 0;
        v0 = v_acc_cnt;
        for (int i = 0; i < 9; i++) v_q.push_back(27'h0400000 + 27'(i));
        repeat (40) tick();
        n_cmp++;
        if (v_acc_cnt - v0 != 8) begin n_err++; $display("FAIL full_accepts: got %0d want 8", v_acc_cnt - v0); end
        w0 = w_acc_cnt;
        op = '{wr: 1'b1, addr: 27'h0000777, data: 32'hCAFE0001};
        w_q.push_back(op);
        k = 0;
        while (w_acc_cnt == w0 && k < 10) begin tick(); k++; end
        n_cmp++;
        if (w_acc_cnt - w0 != 1 || v_acc_cnt - v0 != 8) begin
            n_err++; $display("FAIL full_write: got w=%0d v=%0d want w=1 v=8", w_acc_cnt - w0, v_acc_cnt - v0);
        end
        rsp_budget = 1;
        k = 0;
        while (v_acc_cnt - v0 < 9 && k < 10) begin tick(); k++; end
        n_cmp++;
        if (v_acc_cnt - v0 != 9) begin n_err++; $display("FAIL full_resume: got %0d want 9", v_acc_cnt - v0); end
        rsp_budget = 1000000;
        k = 0;
        while (mem_q.size() != 0 && k < 50) begin tick(); k++; end
        repeat (2) tick();
        n_cmp++;
        if (v_got.size() != 9) begin n_err++; $display("FAIL full_rsp_count: got %0d want 9", v_got.size()); end
        for (int i = 0; i < v_got.size() && i < v_exp.size(); i++) begin
            n_cmp++;
            if (v_got[i] !== v_exp[i]) begin n_err++; $display("FAIL full_v_data[%0d]: got %h want %h", i, v_got[i], v_exp[i]); end
        end
        n_cmp++;
        if (wr_got.size() != 1 || wr_got[0].addr !== op.addr || wr_got[0].data !== op.data) begin
            n_err++; $display("FAIL full_write_cmd: got %0d writes want 1 to %h", wr_got.size(), op.addr);
        end
    endtask

    task automatic test_random();
        int k;
        wop_t op;
        clear_logs();
        lat_lo = 1; lat_hi = 12;
        vrun_max = 0;
        mem_ready_rand = 1;
        for (int i = 0; i < 500; i++) begin
            if (v_q.size() < 2 && $urandom_range(0, 2) != 0) v_q.push_back(27'($urandom));
            if (w_q.size() < 2 && $urandom_range(0, 3) == 0) begin
                op.wr = 1'($urandom_range(0, 1)); op.addr = 27'($urandom); op.data = $urandom;
                w_q.push_back(op);
            end
            tick();
        end
        mem_ready_rand = 0;
        k = 0;
        while ((v_q.size() != 0 || w_q.size() != 0 || mem_q.size() != 0) && k < 600) begin tick(); k++; end
        repeat (3) tick();
        n_cmp++;
        if (v_got.size() != v_exp.size() || w_got.size() != w_exp.size() || wr_got.size() != wr_exp.size()) begin
            n_err++; $display("FAIL rand_counts: got v%0d w%0d wr%0d want v%0d w%0d wr%0d", v_got.size(), w_got.size(),
                wr_got.size(), v_exp.size(), w_exp.size(), wr_exp.size());
        end
        for (int i = 0; i < v_got.size() && i < v_exp.size(); i++) begin
            n_cmp++;
            if (v_got[i] !== v_exp[i]) begin n_err++; $display("FAIL rand_v[%0d]: got %h want %h", i, v_got[i], v_exp[i]); end
        end
        for (int i = 0; i < w_got.size() && i < w_exp.size(); i++) begin
            n_cmp++;
            if (w_got[i] !== w_exp[i]) begin n_err++; $display("FAIL rand_w[%0d]: got %h want %h", i, w_got[i], w_exp[i]); end
        end
        for (int i = 0; i < wr_got.size() && i < wr_exp.size(); i++) begin
            n_cmp++;
            if (wr_got[i].addr !== wr_exp[i].addr || wr_got[i].data !== wr_exp[i].data) begin
                n_err++; $display("FAIL rand_wr[%0d]: got %h:%h want %h:%h", i, wr_got[i].addr, wr_got[i].data,
                    wr_exp[i].addr, wr_exp[i].data);
            end
        end
        n_cmp++;
        if (vrun_max > 16) begin n_err++; $display("FAIL rand_starve_bound: got %0d want <=16", vrun_max); end
        n_cmp++;
        if (s_rsp_err !== 1'b0) begin n_err++; $display("FAIL rand_rsp_err: got %b want 0", s_rsp_err); end
    endtask

    task automatic test_backpressure_error();
        int w0, k, bad;
        wop_t op;
        clear_logs();
        op = '{wr: 1'b1, addr: 27'($urandom), data: $urandom};
        mem_ready = 1'b0;
        w_q.push_back(op);
        bad = 0;
        for (int i = 0; i <= 10; i++) begin
            tick();
            if (i >= 1) begin
                n_cmp++;
                if ({s_avl_write, s_avl_read, s_bb, s_w_ready, s_v_ready, s_avl_addr, s_avl_wdata} !==
                    {1'b1, 1'b0, (i == 1), 1'b0, 1'b0, op.addr, op.data}) begin
                    n_err++; $display("FAIL hold_cycle%0d: got wr=%b rd=%b bb=%b rdy=%b/%b %h:%h want 1 0 %b 0/0 %h:%h",
                        i, s_avl_write, s_avl_read, s_bb, s_w_ready, s_v_ready, s_avl_addr, s_avl_wdata,
                        (i == 1), op.addr, op.data);
                end
            end
        end
        mem_ready = 1'b1;
        w0 = w_acc_cnt;
        k = 0;
        while (w_acc_cnt == w0 && k < 5) begin tick(); k++; end
        n_cmp++;
        if (wr_got.size() != 1 || wr_got[0].data !== op.data) begin
            n_err++; $display("FAIL hold_release: got %0d writes want 1", wr_got.size());
        end
        mem_q.push_back('{due: cyc, data: 32'hBAD0BAD0});
        tick();
        tick();
        n_cmp++;
        if ({s_v_rv, s_w_rv, s_rsp_err} !== 3'b000) begin
            n_err++; $display("FAIL spurious_valid: got v=%b w=%b err=%b want 0 0 0", s_v_rv, s_w_rv, s_rsp_err);
        end
        tick();
        n_cmp++;
        if (s_rsp_err !== 1'b1) begin n_err++; $display("FAIL rsp_err_set: got %b want 1", s_rsp_err); end
        for (int i = 0; i < 10; i++) begin
            tick();
            if (s_rsp_err !== 1'b1) bad++;
        end
        n_cmp++;
        if (bad != 0) begin n_err++; $display("FAIL rsp_err_sticky: got %0d cleared cycles want 0", bad); end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        test_reset();
        test_single_read();
        test_starvation();
        test_interleave();
        test_full_fifo();
        test_random();
        test_backpressure_error();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

endmodule
